// File: rtl/pu_layer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pu_layer_sequencer                                         |
// | Description : Walks a processing unit through max_layers layers: fetch   |
// |               each layer's configuration word, launch the PU, wait for   |
// |               completion, and pulse all_done at the end of the run.      |
// | Options     : PU_SEQ_TIMEOUT_EN enables the RUN-state watchdog.          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module pu_layer_sequencer #(
    parameter int LAYER_PARAM_WIDTH = 10,
    parameter int CFG_WIDTH         = 32,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [LAYER_PARAM_WIDTH-1:0] max_layers,
    output logic                         cfg_req,
    output logic [LAYER_PARAM_WIDTH-1:0] cfg_addr,
    input  logic                         cfg_ack,
    input  logic [CFG_WIDTH-1:0]         cfg_data,
    output logic [CFG_WIDTH-1:0]         layer_cfg,
    output logic [LAYER_PARAM_WIDTH-1:0] layer_idx,
    output logic                         layer_start,
    input  logic                         layer_done,
    output logic                         busy,
    output logic                         all_done,
    output logic                         error,
    output logic [2:0]                   state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [LAYER_PARAM_WIDTH-1:0] c_IDX_ONE = LAYER_PARAM_WIDTH'(1);

    state_t                         state_q, state_d;
    logic [LAYER_PARAM_WIDTH-1:0]   max_q,   max_d;
    logic [LAYER_PARAM_WIDTH-1:0]   idx_q,   idx_d;
    logic [CFG_WIDTH-1:0]           cfg_q,   cfg_d;
    logic                           wd_expired;

    // State, latched layer count, index and configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            max_q   <= '0;
            idx_q   <= '0;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            cfg_q   <= cfg_d;
        end
    end

    // Next-state logic; layer count is compared against the copy latched at start
    // so later changes on max_layers cannot disturb a run in progress.
    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        idx_d   = idx_q;
        cfg_d   = cfg_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    max_d = max_layers;
                    if (max_layers == '0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (cfg_ack) begin
                    cfg_d   = cfg_data;
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (layer_done) begin
                    // Last index is max-1, so the largest legal count never wraps idx.
                    if (idx_q == max_q - c_IDX_ONE) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + c_IDX_ONE;
                        state_d = S_FETCH;
                    end
                end else if (wd_expired) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef PU_SEQ_TIMEOUT_EN
    localparam int c_WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [c_WD_W-1:0] wd_q;
    logic              error_q;

    // RUN-cycle counter; the START cycle precedes every RUN entry, so clear it there
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
        end else if (state_q == S_START) begin
            wd_q <= '0;
        end else if (state_q == S_RUN) begin
            wd_q <= wd_q + c_WD_W'(1);
        end
    end

    assign wd_expired = (wd_q == c_WD_W'(TIMEOUT_CYCLES - 1));

    // Sticky watchdog flag, cleared by reset or by the next accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (state_q == S_RUN && !layer_done && wd_expired) begin
            error_q <= 1'b1;
        end else if (state_q == S_IDLE && start) begin
            error_q <= 1'b0;
        end
    end

    assign error = error_q;
`else
    // Watchdog absent: RUN waits for layer_done forever and the limit is unused.
    localparam int c_timeout_unused = TIMEOUT_CYCLES;

    assign wd_expired = 1'b0;
    assign error      = 1'b0;
`endif

    assign cfg_req     = (state_q == S_FETCH);
    assign cfg_addr    = idx_q;
    assign layer_cfg   = cfg_q;
    assign layer_idx   = idx_q;
    assign layer_start = (state_q == S_START);
    assign busy        = (state_q != S_IDLE);
    assign all_done    = (state_q == S_DONE);
    assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pu_layer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pu_layer_sequencer                                      |
// | Description : Self-checking bench for pu_layer_sequencer. Acts as the    |
// |               configuration memory and the PU, and checks run-level      |
// |               results against expectations derived from layer counts     |
// |               and the handshake delays chosen per layer.                 |
// | Options     : PU_SEQ_TIMEOUT_EN also exercises the watchdog.             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_pu_layer_sequencer;

    localparam int LW = 10;
    localparam int CW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] max_layers;
    logic          cfg_req;
    logic [LW-1:0] cfg_addr;
    logic          cfg_ack;
    logic [CW-1:0] cfg_data;
    logic [CW-1:0] layer_cfg;
    logic [LW-1:0] layer_idx;
    logic          layer_start;
    logic          layer_done;
    logic          busy;
    logic          all_done;
    logic          error;
    logic [2:0]    state;

    int vectors    = 0;
    int miscompares = 0;

    logic [CW-1:0] mem [0:(1<<LW)-1];

    pu_layer_sequencer #(
        .LAYER_PARAM_WIDTH (LW),
        .CFG_WIDTH         (CW),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .max_layers  (max_layers),
        .cfg_req     (cfg_req),
        .cfg_addr    (cfg_addr),
        .cfg_ack     (cfg_ack),
        .cfg_data    (cfg_data),
        .layer_cfg   (layer_cfg),
        .layer_idx   (layer_idx),
        .layer_start (layer_start),
        .layer_done  (layer_done),
        .busy        (busy),
        .all_done    (all_done),
        .error       (error),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Every output at its reset value, observed in the current cycle
    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"},       64'(state),       64'd0);
        chk({tag, "_layer_idx"},   64'(layer_idx),   64'd0);
        chk({tag, "_layer_cfg"},   64'(layer_cfg),   64'd0);
        chk({tag, "_cfg_req"},     64'(cfg_req),     64'd0);
        chk({tag, "_layer_start"}, 64'(layer_start), 64'd0);
        chk({tag, "_all_done"},    64'(all_done),    64'd0);
        chk({tag, "_busy"},        64'(busy),        64'd0);
        chk({tag, "_error"},       64'(error),       64'd0);
    endtask

    // One complete run acting as memory and PU. a_fix/r_fix < 0 pick random
    // per-layer delays: the ack comes in the (a+1)-th cfg_req cycle and
    // layer_done in the (r+1)-th RUN cycle. Each layer therefore costs
    // a+r+3 cycles, and all_done is captured on edge 2 + sum(a+r+3) counted
    // from the edge that captures start. abort_at >= 0 returns as soon as
    // layer abort_at is in RUN.
    task automatic do_run(input int n, input int a_fix, input int r_fix, input bit noise,
                          input int abort_at, output int edges, output int exp_edges,
                          output int starts, output bit aborted);
        int  a_l[$];
        int  r_l[$];
        int  lay;
        int  fcnt;
        int  rcnt;
        int  cyc;
        bit  prev_done;
        bit  seen_done;
        logic [LW-1:0] held_addr;
        exp_edges = 2;
        for (int i = 0; i < n; i++) begin
            a_l.push_back(a_fix >= 0 ? a_fix : int'($urandom_range(0, 7)));
            r_l.push_back(r_fix >= 0 ? r_fix : int'($urandom_range(0, 9)));
            exp_edges += a_l[i] + r_l[i] + 3;
        end
        starts = 0; lay = 0; fcnt = 0; rcnt = 0; prev_done = 1'b0;
        seen_done = 1'b0; aborted = 1'b0; held_addr = '0; edges = 0;

        @(negedge clk);
        max_layers = LW'(n);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (noise) max_layers = LW'($urandom);
        cyc = 1;
        while (cyc < 20000) begin
            chk("busy_in_run", 64'(busy), 64'd1);
            if (prev_done && lay < n) chk("turnaround_cfg_req", 64'(cfg_req), 64'd1);
            if (cfg_req) begin
                if (fcnt == 0) begin
                    chk("cfg_addr", 64'(cfg_addr), 64'(lay));
                    held_addr = cfg_addr;
                end else begin
                    chk("cfg_addr_stable", 64'(cfg_addr), 64'(held_addr));
                end
                fcnt++;
            end
            if (layer_start) begin
                chk("start_idx", 64'(layer_idx), 64'(lay));
                chk("start_cfg", 64'(layer_cfg), 64'(mem[lay]));
                starts++;
            end
            if (all_done) begin
                seen_done = 1'b1;
                break;
            end
            if (abort_at >= 0 && state == 3'd3 && lay == abort_at) begin
                aborted = 1'b1;
                break;
            end
            cfg_ack    = 1'b0;
            layer_done = 1'b0;
            start      = 1'b0;
            cfg_data   = $urandom;
            if (cfg_req && fcnt == a_l[lay] + 1) begin
                cfg_ack  = 1'b1;
                cfg_data = mem[cfg_addr];
                fcnt     = 0;
            end
            prev_done = 1'b0;
            if (state == 3'd3) begin
                rcnt++;
                if (rcnt == r_l[lay] + 1) begin
                    layer_done = 1'b1;
                    prev_done  = 1'b1;
                    rcnt       = 0;
                    lay++;
                end
            end
            if (noise) begin
                if (state != 3'd3 && $urandom_range(0, 2) == 0) layer_done = 1'b1;
                if (state != 3'd0 && $urandom_range(0, 2) == 0) start = 1'b1;
                max_layers = LW'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        cfg_ack = 1'b0; layer_done = 1'b0; start = 1'b0;
        edges = cyc + 1;
        if (!aborted) begin
            chk("all_done_seen", 64'(seen_done), 64'd1);
            @(negedge clk);
            chk("all_done_single", 64'(all_done), 64'd0);
            chk("busy_after", 64'(busy), 64'd0);
            chk("idle_after", 64'(state), 64'd0);
            if (n > 0) begin
                chk("idx_hold", 64'(layer_idx), 64'(n - 1));
                chk("cfg_hold", 64'(layer_cfg), 64'(mem[n-1]));
            end
        end
    endtask

    typedef struct {
        int n;
        int a;
        int r;
        bit noise;
        int exp_edges;
        int exp_starts;
    } vec_t;

    vec_t vt [6];

    initial begin
        int  edges;
        int  exp_e;
        int  nst;
        bit  ab;
        int  n;
        int  quiet;

        vt[0] = '{n: 3,    a: 1, r: 4, noise: 1'b0, exp_edges: 26,   exp_starts: 3};
        vt[1] = '{n: 0,    a: 0, r: 0, noise: 1'b0, exp_edges: 2,    exp_starts: 0};
        vt[2] = '{n: 2,    a: 7, r: 2, noise: 1'b1, exp_edges: 26,   exp_starts: 2};
        vt[3] = '{n: 1,    a: 0, r: 0, noise: 1'b0, exp_edges: 5,    exp_starts: 1};
        vt[4] = '{n: 5,    a: 2, r: 0, noise: 1'b1, exp_edges: 27,   exp_starts: 5};
        vt[5] = '{n: 1023, a: 0, r: 0, noise: 1'b0, exp_edges: 3071, exp_starts: 1023};

        for (int i = 0; i < (1 << LW); i++) mem[i] = $urandom;

        reset = 1'b1; start = 1'b0; max_layers = '0;
        cfg_ack = 1'b0; cfg_data = '0; layer_done = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        reset = 1'b0;

        // Reset outranks a simultaneous start
        @(negedge clk);
        reset = 1'b1; start = 1'b1; max_layers = LW'(3);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk_reset_outputs("rst_vs_start");

        for (int i = 0; i < 6; i++) begin
            do_run(vt[i].n, vt[i].a, vt[i].r, vt[i].noise, -1, edges, exp_e, nst, ab);
            chk($sformatf("vec%0d_done_edges", i), 64'(edges), 64'(vt[i].exp_edges));
            chk($sformatf("vec%0d_layer_starts", i), 64'(nst), 64'(vt[i].exp_starts));
        end

        for (int k = 0; k < 12; k++) begin
            n = int'($urandom_range(0, 6));
            do_run(n, -1, -1, 1'(k & 1), -1, edges, exp_e, nst, ab);
            chk($sformatf("rnd%0d_done_edges", k), 64'(edges), 64'(exp_e));
            chk($sformatf("rnd%0d_layer_starts", k), 64'(nst), 64'(n));
        end

        // Reset while layer 1 of 4 is running, colliding with layer_done and start
        do_run(4, 1, 6, 1'b0, 1, edges, exp_e, nst, ab);
        chk("abort_reached", 64'(ab), 64'd1);
        reset = 1'b1; layer_done = 1'b1; start = 1'b1; cfg_ack = 1'b1;
        @(negedge clk);
        reset = 1'b0; layer_done = 1'b0; start = 1'b0; cfg_ack = 1'b0;
        chk_reset_outputs("abort");
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (all_done || busy) quiet++;
        end
        chk("abort_quiet", 64'(quiet), 64'd0);

`ifdef PU_SEQ_TIMEOUT_EN
        begin
            int rc;
            int guard;
            @(negedge clk);
            max_layers = LW'(2); start = 1'b1;
            @(negedge clk);
            start = 1'b0; rc = 0; guard = 0;
            while (!all_done && guard < 200) begin
                cfg_ack  = cfg_req;
                cfg_data = mem[cfg_addr];
                if (state == 3'd3) rc++;
                @(negedge clk);
                guard++;
            end
            cfg_ack = 1'b0;
            chk("wd_run_cycles", 64'(rc), 64'(TO));
            chk("wd_all_done", 64'(all_done), 64'd1);
            chk("wd_error", 64'(error), 64'd1);
            @(negedge clk);
            chk("wd_error_sticky", 64'(error), 64'd1);
            max_layers = LW'(1); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("wd_error_cleared", 64'(error), 64'd0);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk_reset_outputs("wd_rst");
        end
`else
        // Without the watchdog a long layer simply keeps waiting
        do_run(1, 0, 40, 1'b0, -1, edges, exp_e, nst, ab);
        chk("long_run_edges", 64'(edges), 64'd45);
        chk("no_error", 64'(error), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
